// File: rtl/gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// gate_sweep_checker
//
// Purpose:
//   Exhaustively sweeps every input vector of a small combinational gate under
//   test. For each vector it drives a_out, waits SETTLE cycles, and then
//   compares the gate output against the expected truth table in one cycle.
//   It counts mismatches, remembers the first failing vector, and reports
//   pass/fail with a one-cycle done pulse at the end of the sweep.
//
// Parameters:
//   N_IN    - gate-under-test input width (1..6)
//   SETTLE  - settle cycles per vector (1..255)
//   EXPECT  - expected truth table; bit i is the expected output for vector i
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   sweep request, sampled only in IDLE
//   a_out      out  [N_IN-1:0] stimulus vector to the gate under test
//   y_in       in   gate-under-test output
//   busy       out  high while settling or sampling
//   done       out  one-cycle completion pulse
//   pass       out  last completed sweep had zero mismatches
//   err_count  out  [N_IN:0] mismatch count of the current or last sweep
//   fail_vec   out  [N_IN-1:0] first failing vector of the current or last sweep
//
// Build option:
//   SWEEP_STOP_ON_FAIL_EN - when defined, the first mismatch ends the sweep
//   immediately (DONE with pass=0, err_count=1, a_out held at the failing
//   vector). When undefined, every vector is swept regardless of mismatches.
// -----------------------------------------------------------------------------
module gate_sweep_checker #(
   parameter int                     N_IN   = 2,
   parameter int                     SETTLE = 4,
   parameter logic [(2**N_IN)-1:0]   EXPECT = 4'b1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [N_IN-1:0]   a_out,
   input  logic              y_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_count,
   output logic [N_IN-1:0]   fail_vec
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Settle counter runs 0..SETTLE-1; the last value hands over to SAMPLE.
   localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [7:0]      CNT_ONE     = 8'd1;
   localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
   localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);

   state_t            state_q, state_d;
   logic [N_IN-1:0]   vec_q,   vec_d;
   logic [7:0]        cnt_q,   cnt_d;
   logic [N_IN:0]     err_q,   err_d;
   logic [N_IN-1:0]   fail_q,  fail_d;
   logic              pass_q,  pass_d;

   logic              mismatch;
   logic              last_vec;

   assign mismatch = (y_in != EXPECT[vec_q]);
   assign last_vec = (vec_q == '1);

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         fail_q  <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         pass_q  <= pass_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fail_d  = fail_q;
      pass_d  = pass_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               vec_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               fail_d  = '0;
               pass_d  = 1'b0;
            end
         end

         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_SAMPLE: begin
            if (mismatch) begin
               err_d = err_q + ERR_ONE;
               // err_q still zero means this is the first mismatch of the sweep
               if (err_q == '0) begin
                  fail_d = vec_q;
               end
            end
`ifdef SWEEP_STOP_ON_FAIL_EN
            if (mismatch) begin
               // a_out stays on the failing vector so it can be inspected
               state_d = S_DONE;
               pass_d  = 1'b0;
            end else if (last_vec) begin
               state_d = S_DONE;
               pass_d  = (err_d == '0);
            end else begin
               state_d = S_SETTLE;
               vec_d   = vec_q + VEC_ONE;
               cnt_d   = '0;
            end
`else
            if (last_vec) begin
               // No wrap: a_out holds all-ones until the next start
               state_d = S_DONE;
               pass_d  = (err_d == '0);
            end else begin
               state_d = S_SETTLE;
               vec_d   = vec_q + VEC_ONE;
               cnt_d   = '0;
            end
`endif
         end

         S_DONE: begin
            // start is ignored here; a held start is taken from IDLE next
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign a_out     = vec_q;
   assign busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
   assign done      = (state_q == S_DONE);
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_checker
//
// Drives gate_sweep_checker (default parameters) against an emulated gate
// whose truth table is chosen per sweep, and compares the results with a
// reference computed directly from the truth tables. Honours
// SWEEP_STOP_ON_FAIL_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_gate_sweep_checker;

   localparam int          N_IN   = 2;
   localparam int          SETTLE = 4;
   localparam logic [3:0]  EXPECT = 4'b1000;
   localparam int          NVEC   = 2 ** N_IN;
   localparam int          LIMIT  = 200;

   logic              clk;
   logic              rst;
   logic              start;
   logic [N_IN-1:0]   a_out;
   logic              y_in;
   logic              busy;
   logic              done;
   logic              pass;
   logic [N_IN:0]     err_count;
   logic [N_IN-1:0]   fail_vec;

   // Truth table of the emulated gate under test
   logic [NVEC-1:0]   gut_tt;

   int n_checks = 0;
   int n_fail   = 0;

   gate_sweep_checker #(
      .N_IN   (N_IN),
      .SETTLE (SETTLE),
      .EXPECT (EXPECT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a_out     (a_out),
      .y_in      (y_in),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_vec  (fail_vec)
   );

   assign y_in = gut_tt[a_out];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference: derived from the truth tables alone.
   task automatic model(input logic [NVEC-1:0] tt,
                        output int e_err, output int e_fail, output int e_pass,
                        output int e_edge, output int e_afinal);
      logic [NVEC-1:0] mism;
      int first;
      mism  = tt ^ EXPECT;
      first = -1;
      e_err = 0;
      for (int i = 0; i < NVEC; i++) begin
         if (mism[i]) begin
            e_err++;
            if (first < 0) first = i;
         end
      end
      e_fail   = (first < 0) ? 0 : first;
      e_pass   = (e_err == 0) ? 1 : 0;
      e_edge   = NVEC * (SETTLE + 1);
      e_afinal = NVEC - 1;
`ifdef SWEEP_STOP_ON_FAIL_EN
      if (first >= 0) begin
         e_err    = 1;
         e_edge   = (first + 1) * (SETTLE + 1);
         e_afinal = first;
      end
`endif
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_err"},  32'(err_count), 0);
      chk({tag, "_fvec"}, 32'(fail_vec), 0);
      chk({tag, "_aout"}, 32'(a_out), 0);
   endtask

   // One sweep: start sampled at edge 0; optional extra start pulse sampled at
   // edge 'extra' (0 = none); 'hold' keeps start high throughout.
   task automatic run_sweep(input string tag, input logic [NVEC-1:0] tt,
                            input int extra, input bit hold);
      int e, done_at, n_done;
      int e_err, e_fail, e_pass, e_edge, e_afinal;
      model(tt, e_err, e_fail, e_pass, e_edge, e_afinal);
      gut_tt  = tt;
      done_at = -1;
      n_done  = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      e = 0;
      while (e < LIMIT) begin
         @(negedge clk);
         if (done === 1'b1) begin
            n_done++;
            if (done_at < 0) done_at = e;
         end
         if (e == 1) begin
            chk({tag, "_busy_e1"}, 32'(busy), 1);
            chk({tag, "_aout_e1"}, 32'(a_out), 0);
         end
         if (done_at >= 0) break;
         start = (hold || (extra != 0 && e + 1 == extra)) ? 1'b1 : 1'b0;
         @(posedge clk);
         e++;
      end
      if (!hold) start = 1'b0;
      chk({tag, "_done_edge"}, 32'(done_at), 32'(e_edge));
      chk({tag, "_pass"},      32'(pass), 32'(e_pass));
      chk({tag, "_err"},       32'(err_count), 32'(e_err));
      chk({tag, "_fvec"},      32'(fail_vec), 32'(e_fail));
      chk({tag, "_aout_end"},  32'(a_out), 32'(e_afinal));
      $display("sweep %s tt=%b done_edge=%0d pass=%0b err=%0d fail_vec=%0d",
               tag, tt, done_at, pass, err_count, fail_vec);
      // One cycle later: back in IDLE, results held, pulse over
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, 32'(done), 0);
      chk({tag, "_idle_busy"}, 32'(busy), 0);
      chk({tag, "_hold_err"},  32'(err_count), 32'(e_err));
      chk({tag, "_hold_pass"}, 32'(pass), 32'(e_pass));
      if (hold) begin
         // Held start is taken from IDLE on the following edge
         @(posedge clk);
         @(negedge clk);
         chk({tag, "_relaunch_busy"}, 32'(busy), 1);
         chk({tag, "_relaunch_err"},  32'(err_count), 0);
         start = 1'b0;
         rst   = 1'b1;
         @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
         check_idle_zero({tag, "_rst"});
      end
   endtask

   initial begin
      int rnd_tt, rnd_extra, n_d;
      rst    = 1'b1;
      start  = 1'b0;
      gut_tt = EXPECT;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_zero("reset");
      start = 1'b1;          // rst has priority over start
      @(posedge clk);
      @(negedge clk);
      check_idle_zero("rst_prio");
      rst   = 1'b0;
      start = 1'b0;

      // Directed sweeps
      run_sweep("and_ok",   4'b1000, 0, 1'b0);
      run_sweep("stuck0",   4'b0000, 0, 1'b0);
      run_sweep("stuck1",   4'b1111, 0, 1'b0);
      run_sweep("restart7", 4'b1000, 7, 1'b0);
      run_sweep("holdstart", 4'b1000, 0, 1'b1);

      // Reset mid-sweep at edge 9
      gut_tt = EXPECT;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);        // edge 0
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);   // edge 8
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);        // edge 9
      @(negedge clk);
      rst = 1'b0;
      check_idle_zero("midrst");
      n_d = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done === 1'b1) n_d++;
      end
      chk("midrst_no_done", 32'(n_d), 0);
      chk("midrst_idle",    32'(busy), 0);
      run_sweep("after_rst", 4'b1000, 0, 1'b0);

      // Randomized gates, some with an ignored extra start
      for (int k = 0; k < 8; k++) begin
         rnd_tt    = $urandom_range(0, NVEC * 2 - 1);
         rnd_extra = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 19) : 0;
         run_sweep($sformatf("rnd%0d", k), rnd_tt[NVEC-1:0], rnd_extra, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
